// File: rtl/fip_div_seq.sv
// Sequential signed fixed-point divider: restoring radix-2, one quotient bit per cycle,
// with valid/ready handshakes on both operand and result sides.
module fip_div_seq #(
  parameter int WIDTH    = 32,
  parameter int FRA_BITS = 16,
  parameter int SAT      = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_z,
  output logic             o_dbz,
  output logic             o_ovf
);

  localparam int N  = WIDTH + FRA_BITS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [WIDTH-1:0] MAX_Z = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_Z = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N-1:0]     HALF  = {{FRA_BITS{1'b0}}, MIN_Z};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [N-1:0]     dvd_reg;
  logic [N-1:0]     quo_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic             neg_reg;
  logic             xneg_reg;
  logic             zero_div_reg;
  logic [WIDTH-1:0] z_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH:0]   rem_shift, diff;
  logic [WIDTH-1:0] q_low, signed_low, fix_z;
  logic             ovf_raw, fix_ovf;

  // Unsigned magnitudes; |MIN| = 2^(WIDTH-1) is exact as an unsigned WIDTH-bit value.
  assign x_mag = i_x[WIDTH-1] ? (~i_x + 1'b1) : i_x;
  assign y_mag = i_y[WIDTH-1] ? (~i_y + 1'b1) : i_y;

  assign rem_shift = {rem_reg, dvd_reg[N-1]};
  assign diff      = rem_shift - {1'b0, div_reg};

  assign q_low      = quo_reg[WIDTH-1:0];
  assign signed_low = neg_reg ? (~q_low + 1'b1) : q_low;
  // A negative magnitude of exactly 2^(WIDTH-1) is MIN and still in range.
  assign ovf_raw    = neg_reg ? (quo_reg > HALF) : (quo_reg >= HALF);

  always_comb begin
    fix_z   = signed_low;
    fix_ovf = 1'b0;
    if (zero_div_reg) begin
      fix_z = xneg_reg ? MIN_Z : MAX_Z;
    end else if (ovf_raw) begin
      fix_ovf = 1'b1;
      if (SAT != 0) fix_z = neg_reg ? MIN_Z : MAX_Z;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (i_valid) state_next = (i_y == '0) ? FIX : CALC;
      CALC: if (cnt_reg == LAST) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      dvd_reg      <= '0;
      quo_reg      <= '0;
      div_reg      <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
      neg_reg      <= 1'b0;
      xneg_reg     <= 1'b0;
      zero_div_reg <= 1'b0;
      z_reg        <= '0;
      dbz_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            dvd_reg      <= {x_mag, {FRA_BITS{1'b0}}};
            div_reg      <= y_mag;
            rem_reg      <= '0;
            quo_reg      <= '0;
            cnt_reg      <= '0;
            neg_reg      <= i_x[WIDTH-1] ^ i_y[WIDTH-1];
            xneg_reg     <= i_x[WIDTH-1];
            zero_div_reg <= (i_y == '0);
          end
        end
        CALC: begin
          dvd_reg <= {dvd_reg[N-2:0], 1'b0};
          rem_reg <= diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_reg <= {quo_reg[N-2:0], ~diff[WIDTH]};
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: begin
          z_reg   <= fix_z;
          dbz_reg <= zero_div_reg;
          ovf_reg <= fix_ovf;
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state_reg == IDLE);
  assign o_valid = (state_reg == DONE);
  assign o_z     = z_reg;
  assign o_dbz   = dbz_reg;
  assign o_ovf   = ovf_reg;

endmodule

// File: tb/tb_fip_div_seq.sv
// Scoreboard bench for fip_div_seq: default, wrap-mode and 16-bit instances.
module tb_fip_div_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic v0, rdy0, ov0, r0, dz0, of0;
  logic [31:0] x0, y0, z0;
  logic v1, rdy1, ov1, r1, dz1, of1;
  logic [31:0] x1, y1, z1;
  logic v2, rdy2, ov2, r2, dz2, of2;
  logic [15:0] x2, y2, z2;

  fip_div_seq #(.WIDTH(32), .FRA_BITS(16), .SAT(1)) d0 (
    .i_clk(clk), .i_rst(rst), .i_valid(v0), .o_ready(rdy0), .i_x(x0), .i_y(y0),
    .o_valid(ov0), .i_ready(r0), .o_z(z0), .o_dbz(dz0), .o_ovf(of0));

  fip_div_seq #(.WIDTH(32), .FRA_BITS(16), .SAT(0)) d1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(rdy1), .i_x(x1), .i_y(y1),
    .o_valid(ov1), .i_ready(r1), .o_z(z1), .o_dbz(dz1), .o_ovf(of1));

  fip_div_seq #(.WIDTH(16), .FRA_BITS(8), .SAT(1)) d2 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy2), .i_x(x2), .i_y(y2),
    .o_valid(ov2), .i_ready(r2), .o_z(z2), .o_dbz(dz2), .o_ovf(of2));

  typedef struct {
    logic [31:0] z;
    logic        dbz;
    logic        ovf;
    int          start;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t me;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
    end
  endtask

  // Latency is counted in edges including the accept edge.
  task automatic score(input string n, input exp_t e, input logic [31:0] z,
                       input logic dz, input logic of);
    chk({n, " z"}, z, e.z);
    chk({n, " dbz"}, {31'b0, dz}, {31'b0, e.dbz});
    chk({n, " ovf"}, {31'b0, of}, {31'b0, e.ovf});
    chk({n, " latency"}, 32'(cyc - e.start), 32'(e.lat));
  endtask

  logic pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;

  always @(negedge clk) begin
    if (ov0 === 1'b1 && !pv0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0 unexpected result z=0x%08h", z0);
      end else begin
        me = q0.pop_front();
        score("d0", me, z0, dz0, of0);
      end
    end
    if (ov1 === 1'b1 && !pv1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1 unexpected result z=0x%08h", z1);
      end else begin
        me = q1.pop_front();
        score("d1", me, z1, dz1, of1);
      end
    end
    if (ov2 === 1'b1 && !pv2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL d2 unexpected result z=0x%04h", z2);
      end else begin
        me = q2.pop_front();
        score("d2", me, {16'b0, z2}, dz2, of2);
      end
    end
    pv0 = (ov0 === 1'b1);
    pv1 = (ov1 === 1'b1);
    pv2 = (ov2 === 1'b1);
  end

  function automatic logic rdy_of(input int i);
    return (i == 0) ? rdy0 : (i == 1) ? rdy1 : rdy2;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
  endfunction

  // Called at a negedge; accept happens on the following posedge.
  task automatic issue(input int inst, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input logic dz, input logic of,
                       input int lat, input bit push);
    exp_t e;
    int n = 0;
    while (rdy_of(inst) !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL issue timeout inst=%0d", inst);
      return;
    end
    case (inst)
      0: begin x0 = x; y0 = y; v0 = 1'b1; end
      1: begin x1 = x; y1 = y; v1 = 1'b1; end
      default: begin x2 = x[15:0]; y2 = y[15:0]; v2 = 1'b1; end
    endcase
    e = '{z, dz, of, cyc, lat};
    if (push) begin
      case (inst)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    x0 = 32'hDEADBEEF; y0 = 32'h13579BDF;
    x1 = 32'hDEADBEEF; y1 = 32'h13579BDF;
    x2 = 16'hBEEF;     y2 = 16'h1357;
  endtask

  task automatic wait_idle(input int inst);
    int n = 0;
    while (!(qsize(inst) == 0 && rdy_of(inst) === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL wait_idle timeout inst=%0d", inst);
    end
  endtask

  task automatic run(input int inst, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] z, input logic dz, input logic of, input int lat);
    issue(inst, x, y, z, dz, of, lat, 1'b1);
    wait_idle(inst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (2) @(negedge clk);
    chk("reset ready/valid", {30'b0, rdy0, ov0}, 32'h2);
    chk("reset z", z0, 32'h0);
    chk("reset dbz/ovf", {30'b0, dz0, of0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run(0, 32'h00020000, 32'h00020000, 32'h00010000, 1'b0, 1'b0, 50);
    run(0, 32'h00000002, 32'h00000003, 32'h0000AAAA, 1'b0, 1'b0, 50);
    run(0, 32'hFFFF0000, 32'h00008000, 32'hFFFE0000, 1'b0, 1'b0, 50);
    run(0, 32'h7FFFFFFF, 32'h00004000, 32'h7FFFFFFF, 1'b0, 1'b1, 50);
    run(0, 32'h80000000, 32'h00004000, 32'h80000000, 1'b0, 1'b1, 50);
    run(0, 32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0, 50);
    run(0, 32'h00050000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2);
    run(0, 32'hFFFB0000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 2);
    run(0, 32'h00000000, 32'hFFFF0000, 32'h00000000, 1'b0, 1'b0, 50);

    // Backpressure, plus an operand pulse during CALC that must be ignored.
    r0 = 1'b0;
    issue(0, 32'h00030000, 32'h00010000, 32'h00030000, 1'b0, 1'b0, 50, 1'b1);
    repeat (5) @(negedge clk);
    chk("calc ready low", {31'b0, rdy0}, 32'h0);
    v0 = 1'b1; x0 = 32'h00010000; y0 = 32'h00010000;
    @(negedge clk);
    v0 = 1'b0;
    n = 0;
    while (ov0 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL backpressure valid timeout");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold z", z0, 32'h00030000);
      chk("hold valid/ready/dbz/ovf", {28'b0, ov0, rdy0, dz0, of0}, 32'h8);
    end
    r0 = 1'b1;
    @(negedge clk);
    chk("release valid/ready", {30'b0, ov0, rdy0}, 32'h1);
    repeat (60) @(negedge clk);
    chk("ignored operand no result", {31'b0, ov0}, 32'h0);

    // Reset 20 cycles into CALC discards the division.
    issue(0, 32'h12340000, 32'h00030000, 32'h0, 1'b0, 1'b0, 50, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset valid/ready", {30'b0, ov0, rdy0}, 32'h1);
    chk("midreset z", z0, 32'h0);
    run(0, 32'h00008000, 32'h00004000, 32'h00020000, 1'b0, 1'b0, 50);
    repeat (60) @(negedge clk);
    chk("midreset no stale result", {31'b0, ov0}, 32'h0);

    run(1, 32'h7FFFFFFF, 32'h00004000, 32'hFFFFFFFC, 1'b0, 1'b1, 50);
    run(1, 32'h80000000, 32'h00004000, 32'h00000000, 1'b0, 1'b1, 50);
    run(1, 32'hFFFF0000, 32'h00008000, 32'hFFFE0000, 1'b0, 1'b0, 50);

    run(2, 32'h00000300, 32'h00000200, 32'h00000180, 1'b0, 1'b0, 26);
    run(2, 32'h0000FB00, 32'h00000000, 32'h00008000, 1'b1, 1'b0, 2);
    run(2, 32'h00007FFF, 32'h00000040, 32'h00007FFF, 1'b0, 1'b1, 26);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fip_div_seq.md
Name: fip_div_seq

Overview:
Parametrised sequential signed fixed-point divider, successor to the combinational 32-bit Q16.16 divider. It uses restoring radix-2 division, one quotient bit per cycle. Operands and results move over valid/ready handshakes. The quotient has configurable width and fraction bits, with selectable saturate or wrap overflow and explicit divide-by-zero and overflow flags. It sits in the ray-triangle intersection path (barycentric/t divides), where a pipelined full-width combinational divide does not meet timing.

Parameters:
WIDTH, 32, total bits of operands and result (signed two's complement, >= 8)
FRA_BITS, 16, fraction bits (0 < FRA_BITS < WIDTH)
SAT, 1, 1 = saturate out-of-range results to MIN/MAX; 0 = wrap (low WIDTH bits of exact signed quotient)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  operand pair valid
o_ready  out  1  divider idle, can accept operands
i_x  in  WIDTH  signed dividend
i_y  in  WIDTH  signed divisor
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_z  out  WIDTH  signed quotient, Q(WIDTH-FRA_BITS).FRA_BITS
o_dbz  out  1  divisor was zero (qualified by o_valid)
o_ovf  out  1  result out of range; saturated (SAT=1) or wrapped (SAT=0) (qualified by o_valid)

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE, o_ready=1, o_valid=0, o_z=0, o_dbz=0, o_ovf=0. Applies from any state; an in-flight division is discarded with no result emitted.
- Let N = WIDTH+FRA_BITS. Internal magnitude dividend = |i_x| << FRA_BITS (N bits). Divisor = |i_y| (WIDTH bits, unsigned). |MIN| = 2^(WIDTH-1) must be represented exactly. Result sign = sign(i_x) XOR sign(i_y).
- States:
  - IDLE: o_ready=1. Accept on edge with i_valid && o_ready. Register magnitudes and sign, clear the iteration counter, go to CALC. If i_y == 0, go to FIX directly.
  - CALC: N cycles. Each cycle shifts the partial remainder left by 1 bit of dividend, trial-subtracts the divisor, and sets quotient bit if non-negative. After the N-th iteration, go to FIX. o_ready=0.
  - FIX: one cycle; applies sign, range check and saturation, registers o_z/o_dbz/o_ovf, then goes to DONE.
  - DONE: o_valid=1. Outputs held stable while i_ready=0. On edge with i_ready=1, go to IDLE, with o_valid=0 and o_ready=1 next cycle. No operand is accepted in DONE.
- Latency: o_valid rises N+2 edges after the accept edge (50 for defaults). For divide-by-zero, it rises 2 edges after accept. Throughput: one division per N+3 cycles when i_ready is held high.
- Rounding: truncation toward zero of the magnitude quotient, then sign applied.
- Range: MAX = 2^(WIDTH-1)-1, MIN = -2^(WIDTH-1).
  - Positive result with magnitude > MAX: overflow.
  - Negative result with magnitude > 2^(WIDTH-1): overflow.
  - Magnitude of exactly 2^(WIDTH-1) with negative sign equals MIN, which is not an overflow.
- On overflow: o_ovf=1. With SAT=1, o_z=MAX or MIN by sign. With SAT=0, o_z = low WIDTH bits of the signed quotient.
- Divide by zero: o_dbz=1, o_ovf=0, o_z=MAX if i_x >= 0 else MIN, regardless of SAT.
- Zero dividend: o_z=0; never yields negative zero issues.
- i_x, i_y may change after the accept edge without affecting the result.
- i_valid is ignored while o_ready=0; there is no queuing.

Test Plan:
- Defaults. Accept x=0x00020000, y=0x00020000 with i_ready=1 -> o_valid exactly 50 edges after accept; o_z=0x00010000, o_dbz=0, o_ovf=0.
- x=2, y=3 -> o_z=43690 (0x0000AAAA), truncated. Then x=0xFFFF0000 (-1.0), y=0x00008000 (0.5) -> o_z=0xFFFE0000 (-2.0).
- SAT=1: x=0x7FFFFFFF, y=0x00004000 -> o_z=0x7FFFFFFF, o_ovf=1. x=0x80000000, y=0x00004000 -> o_z=0x80000000, o_ovf=1. x=0x80000000, y=0x00010000 -> o_z=0x80000000, o_ovf=0. SAT=0 instance with x=0x7FFFFFFF, y=0x00004000 -> o_z=0xFFFFFFFC (low 32 bits), o_ovf=1.
- Divide by zero: x=0x00050000, y=0 -> o_valid 2 edges after accept, o_z=0x7FFFFFFF, o_dbz=1. x=0xFFFB0000, y=0 -> o_z=0x80000000, o_dbz=1.
- Backpressure/handshake: hold i_ready=0 for 10 cycles after o_valid -> o_z/flags stable, o_ready=0. Pulse i_valid with new operands during CALC -> ignored. Release i_ready -> o_valid falls next cycle, o_ready=1.
- Reset mid-operation: assert i_rst for 1 cycle 20 cycles into CALC -> next cycle o_valid=0, o_ready=1, o_z=0. A fresh division (0x00008000/0x00004000) then yields 0x00020000 with normal latency. A second instance with WIDTH=16, FRA_BITS=8: 0x0300/0x0200 -> 0x0180 after 26 edges.
